// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the FIFO read-side unpacker:
//   - beat_idx_t : container type used to pass a beat index to slice_sel
//   - idx_bits   : width of the beat-index register for a WD/WO ratio
//   - slice_sel  : extracts beat number idx from a word, LSB- or MSB-first
// No ports (package).
// -----------------------------------------------------------------------------
package fifo_pkg;

  // Widest word slice_sel can handle; callers zero-extend into this width.
  localparam int unsigned SEL_W = 256;

  typedef logic [7:0] beat_idx_t;

  // Width of the beat index for ratio R = wd/wo.  When R=1 the index is
  // logically zero-width; one bit is kept and held at 0 so the port and
  // register declarations stay legal.
  function automatic int unsigned idx_bits(input int unsigned wd,
                                           input int unsigned wo);
    int unsigned r;
    r = wd / wo;
    return (r > 32'd1) ? $clog2(r) : 32'd1;
  endfunction

  // Returns the word shifted so that beat idx sits in the low wo bits.
  // The caller keeps only the low wo bits of the result.
  function automatic logic [SEL_W-1:0] slice_sel(input logic [SEL_W-1:0] word,
                                                 input beat_idx_t        idx,
                                                 input int unsigned      wd,
                                                 input int unsigned      wo,
                                                 input bit               msb_first);
    int unsigned r;
    int unsigned pos;
    r   = wd / wo;
    pos = msb_first ? (r - 32'd1 - 32'(idx)) : 32'(idx);
    return word >> (pos * wo);
  endfunction

endpackage

// File: rtl/fifo_rd_unpack_shreg.sv
// -----------------------------------------------------------------------------
// unpack_shreg
// Holds the popped word and walks through its beats.
// Ports:
//   clk, rst        : clock, async active-high reset
//   load_i          : capture word_i, present beat 0
//   advance_i       : present the next beat of the held word
//   clear_i         : drop the held word (index to 0, last to 0)
//   word_i [WD]     : word to capture on load
//   data_o [WO]     : registered current beat
//   last_o          : registered "current beat is the final one"
// Strobe priority is clear > load > advance; the parent never raises
// clear and load together.
// -----------------------------------------------------------------------------
module unpack_shreg
  import fifo_pkg::*;
#(
  parameter int unsigned WD        = 32,
  parameter int unsigned WO        = 8,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          advance_i,
  input  logic          clear_i,
  input  logic [WD-1:0] word_i,
  output logic [WO-1:0] data_o,
  output logic          last_o
);

  localparam int unsigned   R        = WD / WO;
  localparam int unsigned   IW       = idx_bits(WD, WO);
  localparam logic [IW-1:0] LAST_IDX = IW'(R - 32'd1);
  localparam bit            MSB_B    = (MSB_FIRST != 32'd0);

  logic [WD-1:0]    hold_q, hold_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WO-1:0]    data_q, data_d;
  logic             last_q, last_d;
  logic [SEL_W-1:0] word_ext_s;
  logic [SEL_W-1:0] hold_ext_s;

  // Next-state for the held word, beat index and registered beat outputs.
  always_comb begin
    hold_d     = hold_q;
    idx_d      = idx_q;
    data_d     = data_q;
    last_d     = last_q;
    word_ext_s = '0;
    hold_ext_s = '0;
    word_ext_s[WD-1:0] = word_i;
    hold_ext_s[WD-1:0] = hold_q;
    if (clear_i) begin
      idx_d  = '0;
      last_d = 1'b0;
    end else if (load_i) begin
      hold_d = word_i;
      idx_d  = '0;
      data_d = WO'(slice_sel(word_ext_s, 8'd0, WD, WO, MSB_B));
      last_d = (R == 32'd1);
    end else if (advance_i) begin
      // With R=1 every beat is last, so advance never fires; keep idx at 0.
      idx_d  = (R > 32'd1) ? (idx_q + IW'(1)) : '0;
      data_d = WO'(slice_sel(hold_ext_s, beat_idx_t'(idx_d), WD, WO, MSB_B));
      last_d = (idx_d == LAST_IDX);
    end else begin
      idx_d = idx_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
      idx_q  <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  assign data_o = data_q;
  assign last_o = last_q;

endmodule

// File: rtl/fifo_rd_unpack.sv
// -----------------------------------------------------------------------------
// fifo_rd_unpack
// Pops WD-bit words from a show-ahead FIFO and streams them as WD/WO beats.
// Ports:
//   rclk, rst          : read clock, async active-high reset
//   fifo_rempty        : FIFO empty flag
//   fifo_rdat [WD]     : FIFO head word (valid while not empty)
//   fifo_ren           : pop strobe (pops the head in the same cycle)
//   m_valid/m_ready    : output beat handshake
//   m_data [WO]        : output beat
//   m_last             : final beat of the word
//   flush              : drop the remaining beats of the held word
//   word_cnt [WC]      : popped-word counter, wraps silently
// -----------------------------------------------------------------------------
module fifo_rd_unpack
  import fifo_pkg::*;
#(
  parameter int unsigned WD        = 32,
  parameter int unsigned WO        = 8,
  parameter int unsigned MSB_FIRST = 0,
  parameter int unsigned WC        = 16
) (
  input  logic          rclk,
  input  logic          rst,
  input  logic          fifo_rempty,
  input  logic [WD-1:0] fifo_rdat,
  output logic          fifo_ren,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [WO-1:0] m_data,
  output logic          m_last,
  input  logic          flush,
  output logic [WC-1:0] word_cnt
);

  logic          busy_q, busy_d;
  logic [WC-1:0] cnt_q, cnt_d;
  logic          xfer_s;
  logic          load_s;
  logic          clear_s;
  logic          adv_s;

  // Load/pop arbitration. Loading on the last-beat transfer gives
  // back-to-back words; this is why fifo_ren depends on m_ready
  // combinationally. rst gating keeps the pop strobe low during reset.
  always_comb begin
    xfer_s  = busy_q & m_ready;
    load_s  = ~fifo_rempty & (~busy_q | (xfer_s & m_last)) & ~flush & ~rst;
    clear_s = flush | (xfer_s & m_last & ~load_s);
    adv_s   = xfer_s & ~m_last & ~flush;
    cnt_d   = load_s ? (cnt_q + WC'(1)) : cnt_q;
    if (flush) begin
      busy_d = 1'b0;
    end else if (load_s) begin
      busy_d = 1'b1;
    end else if (xfer_s & m_last) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
  end

  // Valid flag and popped-word counter.
  always_ff @(posedge rclk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  unpack_shreg #(
    .WD        (WD),
    .WO        (WO),
    .MSB_FIRST (MSB_FIRST)
  ) u_shreg (
    .clk       (rclk),
    .rst       (rst),
    .load_i    (load_s),
    .advance_i (adv_s),
    .clear_i   (clear_s),
    .word_i    (fifo_rdat),
    .data_o    (m_data),
    .last_o    (m_last)
  );

  assign fifo_ren = load_s;
  assign m_valid  = busy_q;
  assign word_cnt = cnt_q;

endmodule
